// File: rtl/turbo_pkg.sv
// Shared turbo-encoder definitions: QPP constants, address width, length flag
// encoding and the interleaver read-FSM state type.
package turbo_pkg;

  localparam int unsigned QPP_AW       = 13;
  localparam int unsigned QPP_K_SHORT  = 1056;
  localparam int unsigned QPP_K_LONG   = 6144;
  localparam int unsigned QPP_F1_SHORT = 17;
  localparam int unsigned QPP_F2_SHORT = 66;
  localparam int unsigned QPP_F1_LONG  = 263;
  localparam int unsigned QPP_F2_LONG  = 480;
  localparam int unsigned QPP_GAP      = 4;

  // Length flag encoding, shared with the encoder FSM
  localparam logic LEN_SHORT = 1'b0;
  localparam logic LEN_LONG  = 1'b1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_GAP
  } rd_state_e;

endpackage

// File: rtl/qpp_addr_gen.sv
// Recursive QPP address generator: i counts 0..K-1, pi follows
// pi(i) = (f1*i + f2*i^2) mod K using only adds and conditional subtracts.
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int unsigned AW = QPP_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic [AW-1:0] k,
  input  logic [AW-1:0] f1,
  input  logic [AW-1:0] f2,
  output logic [AW-1:0] i,
  output logic [AW-1:0] pi,
  output logic          last
);

  logic [AW-1:0] k_q;
  logic [AW-1:0] g;
  logic [AW-1:0] g_inc;

  // Operands are already reduced mod m, so one conditional subtract suffices
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[AW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      i     <= '0;
      pi    <= '0;
      k_q   <= '0;
      g     <= '0;
      g_inc <= '0;
    end else if (start) begin
      i     <= '0;
      pi    <= '0;
      k_q   <= k;
      g     <= mod_add(f1, f2, k);
      g_inc <= mod_add(f2, f2, k);
    end else if (step) begin
      i     <= i + AW'(1);
      pi    <= mod_add(pi, g, k_q);
      g     <= mod_add(g, g_inc, k_q);
    end
  end

  assign last = (i == k_q - AW'(1));

endmodule

// File: rtl/qpp_interleaver.sv
// Ping-pong code-block buffer replaying each block in natural (ck) and QPP
// interleaved (ckp) order. Define QPP_BYPASS_EN to add the bypass input.
module qpp_interleaver
  import turbo_pkg::*;
#(
  parameter int unsigned K_SHORT  = QPP_K_SHORT,
  parameter int unsigned K_LONG   = QPP_K_LONG,
  parameter int unsigned F1_SHORT = QPP_F1_SHORT,
  parameter int unsigned F2_SHORT = QPP_F2_SHORT,
  parameter int unsigned F1_LONG  = QPP_F1_LONG,
  parameter int unsigned F2_LONG  = QPP_F2_LONG,
  parameter int unsigned AW       = QPP_AW,
  parameter int unsigned GAP      = QPP_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_length,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_ck,
  output logic       out_ckp,
  output logic       out_length,
  output logic [1:0] bank_full
`ifdef QPP_BYPASS_EN
  ,
  input  logic       bypass
`endif
);

  localparam logic [AW-1:0] KS  = AW'(K_SHORT);
  localparam logic [AW-1:0] KL  = AW'(K_LONG);
  localparam logic [AW-1:0] F1S = AW'(F1_SHORT);
  localparam logic [AW-1:0] F2S = AW'(F2_SHORT);
  localparam logic [AW-1:0] F1L = AW'(F1_LONG);
  localparam logic [AW-1:0] F2L = AW'(F2_LONG);
  localparam int unsigned   GW  = $clog2(GAP + 1);

  logic mem [2][1<<AW];

  logic          wbank;
  logic [AW-1:0] waddr;
  logic          wlen;
  logic [1:0]    bank_len;
  logic          accept;
  logic          cur_len;
  logic [AW-1:0] cur_k;
  logic          wr_last;

  rd_state_e     state, state_n;
  logic          rbank;
  logic [GW-1:0] gap_cnt;
  logic          start, step, free;
  logic [AW-1:0] rd_i, rd_pi, rd_pa;
  logic          rd_last;

  assign in_ready = ~bank_full[wbank];
  assign accept   = in_valid & in_ready;
  assign cur_len  = (waddr == '0) ? in_length : wlen;
  assign cur_k    = (cur_len == LEN_LONG) ? KL : KS;
  assign wr_last  = (waddr == cur_k - AW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank     <= 1'b0;
      waddr     <= '0;
      wlen      <= LEN_SHORT;
      bank_full <= '0;
      bank_len  <= '0;
    end else begin
      if (accept) begin
        if (waddr == '0) wlen <= in_length;
        if (wr_last) begin
          bank_full[wbank] <= 1'b1;
          bank_len[wbank]  <= cur_len;
          wbank            <= ~wbank;
          waddr            <= '0;
        end else begin
          waddr <= waddr + AW'(1);
        end
      end
      // The write side only completes an empty bank, so this never collides
      if (free) bank_full[rbank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wbank][waddr] <= in_bit;
  end

  qpp_addr_gen #(.AW(AW)) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .k     (bank_len[rbank] ? KL  : KS),
    .f1    (bank_len[rbank] ? F1L : F1S),
    .f2    (bank_len[rbank] ? F2L : F2S),
    .i     (rd_i),
    .pi    (rd_pi),
    .last  (rd_last)
  );

`ifdef QPP_BYPASS_EN
  logic byp;
  always_ff @(posedge clk) begin
    if (rst)        byp <= 1'b0;
    else if (start) byp <= bypass;
  end
  assign rd_pa = byp ? rd_i : rd_pi;
`else
  assign rd_pa = rd_pi;
`endif

  // GAP state lasts GAP-1 cycles: with the read latency and the 1-cycle IDLE
  // this yields exactly GAP idle output cycles between back-to-back blocks.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    free    = 1'b0;
    case (state)
      RD_IDLE: if (bank_full[rbank]) begin
        start   = 1'b1;
        state_n = RD_READ;
      end
      RD_READ: begin
        step = 1'b1;
        if (rd_last) state_n = RD_GAP;
      end
      RD_GAP: if (gap_cnt == GW'(GAP - 2)) begin
        free    = 1'b1;
        state_n = RD_IDLE;
      end
      default: state_n = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      rbank      <= 1'b0;
      gap_cnt    <= '0;
      out_valid  <= 1'b0;
      out_ck     <= 1'b0;
      out_ckp    <= 1'b0;
      out_length <= 1'b0;
    end else begin
      state     <= state_n;
      gap_cnt   <= (state == RD_GAP) ? gap_cnt + GW'(1) : '0;
      out_valid <= step;
      out_ck    <= step & mem[rbank][rd_i];
      out_ckp   <= step & mem[rbank][rd_pa];
      if (step) out_length <= bank_len[rbank];
      if (free) rbank <= ~rbank;
    end
  end

endmodule

// File: tb/tb_qpp_interleaver.sv
// Self-checking bench for qpp_interleaver: random blocks scored against a
// direct (f1*i + f2*i^2) mod K permutation model.
`timescale 1ns/1ps
module tb_qpp_interleaver;

  localparam int unsigned KS  = 40;
  localparam int unsigned F1S = 3;
  localparam int unsigned F2S = 10;
  localparam int unsigned KL  = 6144;
  localparam int unsigned F1L = 263;
  localparam int unsigned F2L = 480;
  localparam int unsigned G   = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_length;
  logic in_ready, out_valid, out_ck, out_ckp, out_length;
  logic [1:0] bank_full;
`ifdef QPP_BYPASS_EN
  logic bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  qpp_interleaver #(
    .K_SHORT (KS),  .K_LONG  (KL),
    .F1_SHORT(F1S), .F2_SHORT(F2S),
    .F1_LONG (F1L), .F2_LONG (F2L),
    .AW      (13),  .GAP     (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_length (in_length),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ck    (out_ck),
    .out_ckp   (out_ckp),
    .out_length(out_length),
    .bank_full (bank_full)
`ifdef QPP_BYPASS_EN
    ,
    .bypass    (bypass)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pi(input int i, input bit len);
    longint k, f1, f2, li;
    k  = len ? KL  : KS;
    f1 = len ? F1L : F1S;
    f2 = len ? F2L : F2S;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  // Scoreboard: blocks accepted by the writer, in order
  bit exp_bits[$];
  bit exp_len[$];
  bit cur_bits [0:8191];
  int gaps[$];
  int pos = 0, cur_k = KS, low_run = 0, blocks_seen = 0, ck_ones = 0, ckp_ones = 0, stalls = 0;
  bit cur_len = 0, cur_byp = 0, after_end = 0, mon_en = 0;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pos != 0) check("valid_contig", out_valid, 1);
      if (out_valid) begin
        if (pos == 0) begin
          if (blocks_seen > 0) gaps.push_back(low_run);
          check("block_pending", exp_len.size() > 0, 1);
          cur_len = (exp_len.size() > 0) ? exp_len.pop_front() : 1'b0;
          cur_k   = cur_len ? KL : KS;
          for (int j = 0; j < cur_k; j++) cur_bits[j] = (exp_bits.size() > 0) ? exp_bits.pop_front() : 1'b0;
`ifdef QPP_BYPASS_EN
          cur_byp = bypass;
`endif
          ck_ones = 0;
          ckp_ones = 0;
          blocks_seen++;
        end
        check("out_length", out_length, cur_len);
        check("out_ck", out_ck, cur_bits[pos]);
        check("out_ckp", out_ckp, cur_byp ? cur_bits[pos] : cur_bits[model_pi(pos, cur_len)]);
        ck_ones  += int'(out_ck);
        ckp_ones += int'(out_ckp);
        pos++;
        if (pos == cur_k) begin
          check("perm_weight", ckp_ones, ck_ones);
          pos = 0;
          after_end = 1;
          low_run = 0;
        end
      end else begin
        if (after_end) begin
          check("length_hold", out_length, cur_len);
          after_end = 0;
        end
        low_run++;
      end
    end
  end

  // gappy: randomly idle in_valid; toggle_at: flip in_length from that bit on
  task automatic send_block(input bit len, input int toggle_at, input int onehot, input bit gappy);
    int k, idx, guard;
    bit rdy;
    bit bits[];
    k = len ? KL : KS;
    bits = new[k];
    for (int j = 0; j < k; j++) bits[j] = (onehot >= 0) ? (j == onehot) : bit'($urandom_range(0, 1));
    idx = 0;
    guard = 0;
    while (idx < k && guard < 20000) begin
      @(negedge clk);
      if (gappy && $urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        in_bit    = bit'($urandom_range(0, 1));
        in_length = bit'($urandom_range(0, 1));
        rdy = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_bit    = bits[idx];
        in_length = (toggle_at > 0 && idx >= toggle_at) ? !len : len;
        rdy = in_ready;
        if (!rdy) stalls++;
      end
      @(posedge clk);
      if (rdy) idx++;
      guard++;
    end
    check("write_done", idx, k);
    if (idx == k) begin
      for (int j = 0; j < k; j++) exp_bits.push_back(bits[j]);
      exp_len.push_back(len);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (!(exp_len.size() == 0 && pos == 0 && low_run > int'(G) + 2) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check("drain_pending", exp_len.size(), 0);
    check("drain_pos", pos, 0);
  endtask

  task automatic new_test();
    gaps.delete();
    blocks_seen = 0;
    stalls = 0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_length = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ck", out_ck, 0);
    check("rst_out_ckp", out_ckp, 0);
    check("rst_out_length", out_length, 0);
    check("rst_bank_full", bank_full, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // One-hot blocks back to back: bit 1 then bit 13 (pi(1) = 13)
    new_test();
    send_block(0, -1, 1, 0);
    send_block(0, -1, 13, 0);
    idle_in();
    wait_drain();
    check("t1_gap_count", gaps.size(), 1);
    if (gaps.size() >= 1) check("t1_gap", gaps[0], G);

    // Random long and short blocks with ragged input
    new_test();
    send_block(1, -1, -1, 1);
    send_block(0, -1, -1, 1);
    idle_in();
    wait_drain();
    check("t2_blocks", blocks_seen, 2);

    // Streamed short, long, short, short: both banks fill, writer stalls
    new_test();
    send_block(0, -1, -1, 0);
    send_block(1, -1, -1, 0);
    send_block(0, -1, -1, 0);
    send_block(0, -1, -1, 0);
    idle_in();
    wait_drain();
    check("t3_blocks", blocks_seen, 4);
    check("t3_ready_stall", stalls > 0, 1);
    check("t3_gap_count", gaps.size(), 3);
    if (gaps.size() >= 3) begin
      check("t3_gap_long_short", gaps[1], G);
      check("t3_gap_short_short", gaps[2], G);
    end

    // in_length flipped mid-block must be ignored
    new_test();
    send_block(0, 10, -1, 1);
    send_block(0, 39, -1, 0);
    idle_in();
    wait_drain();
    check("t4_blocks", blocks_seen, 2);

    // Reset during read-out of a long block with the other bank full
    new_test();
    send_block(1, -1, -1, 0);
    send_block(0, -1, -1, 0);
    idle_in();
    begin
      int guard = 0;
      while (pos < 500 && guard < 20000) begin
        @(posedge clk);
        guard++;
      end
    end
    check("t5_reach_bit500", pos, 500);
    check("t5_other_full", bank_full, 2'b11);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_bank_full", bank_full, 0);
    exp_bits.delete();
    exp_len.delete();
    pos = 0; after_end = 0; low_run = 0;
    new_test();
    rst = 1'b0;
    mon_en = 1'b1;
    send_block(0, -1, -1, 1);
    idle_in();
    wait_drain();
    check("t5_fresh_blocks", blocks_seen, 1);

`ifdef QPP_BYPASS_EN
    new_test();
    bypass = 1'b1;
    send_block(0, -1, -1, 0);
    idle_in();
    wait_drain();
    bypass = 1'b0;
    check("t6_blocks", blocks_seen, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d mismatched", n_err);
    $fatal(1, "watchdog");
  end

endmodule
